// File: rtl/sum_display_pkg.sv
// Shared types, widths and segment patterns for the sum display block.
package sum_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 12;
    localparam int BCD_W      = 16;
    localparam int SR_W       = BCD_W + VALUE_W;

    // Active-high pattern with every segment dark.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Decimal digit to active-high {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] seg_lookup(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] r;
        r = sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[VALUE_W+4*i +: 4] >= 4'd5)
                r[VALUE_W+4*i +: 4] = r[VALUE_W+4*i +: 4] + 4'd3;
        end
        return r << 1;
    endfunction

endpackage

// File: rtl/sum_display_seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment pattern with blanking.
module seg7_decode
    import sum_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] pattern
);

    // Blanked digits go dark regardless of the nibble value.
    always_comb begin
        pattern = SEG_BLANK;
        if (!blank)
            pattern = seg_lookup(digit);
    end

endmodule

// File: rtl/sum_display.sv
// Iterative binary-to-BCD converter feeding a 4-digit multiplexed 7-segment scanner.
// The scanner only ever reads the committed bcd register, never the shift register.
module sum_display
    import sum_display_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [BCD_W-1:0]      bcd,
    output logic                  busy
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0] ITER_LAST = 4'(VALUE_W - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = SEG_ACTIVE_LOW ? '1 : '0;

    state_t               state;
    state_t               state_nxt;
    logic [SR_W-1:0]      shreg;
    logic [VALUE_W-1:0]   last_value;
    logic [VALUE_W-1:0]   cap_value;
    logic [3:0]           iter_cnt;

    logic [CNT_W-1:0]     refresh_cnt;
    logic [1:0]           digit_idx;
    logic [3:0]           sel_nibble;
    logic                 sel_blank;
    logic [BCD_W-1:0]     upper_bcd;
    logic [6:0]           seg_pat;
    logic [NUM_DIGITS-1:0] an_pat;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: start on a fresh value, run 12 shifts, then commit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (value != last_value) state_nxt = SHIFT;
            SHIFT:   if (iter_cnt == ITER_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath: capture, shift-and-correct, and commit the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            cap_value  <= '0;
            last_value <= '0;
            iter_cnt   <= '0;
            busy       <= 1'b0;
            bcd        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != last_value) begin
                        shreg     <= {{BCD_W{1'b0}}, value};
                        cap_value <= value;
                        iter_cnt  <= '0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    shreg    <= dabble_step(shreg);
                    iter_cnt <= iter_cnt + 4'd1;
                end
                DONE: begin
                    bcd        <= shreg[SR_W-1 -: BCD_W];
                    last_value <= cap_value;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Refresh timer: advance to the next digit every REFRESH_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Pick the scanned nibble; blank it if it and every higher nibble are zero.
    always_comb begin
        sel_nibble = bcd[{digit_idx, 2'b00} +: 4];
        upper_bcd  = bcd >> {digit_idx, 2'b00};
        sel_blank  = (digit_idx != 2'd0) && (upper_bcd == '0);
        an_pat     = NUM_DIGITS'(1) << digit_idx;
    end

    seg7_decode u_decode (
        .digit   (sel_nibble),
        .blank   (sel_blank),
        .pattern (seg_pat)
    );

    // Output registers with polarity applied; dark until the first scan cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~seg_pat : seg_pat;
            an  <= SEG_ACTIVE_LOW ? ~an_pat : an_pat;
        end
    end

endmodule

// File: tb/tb_sum_display.sv
// Directed and randomized bench for sum_display with a decimal reference model.
module tb_sum_display;

    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] value = 12'd0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    int disp_val = 0;
    int tb_last = 0;
    bit scan_en = 1'b1;

    int         p10[4] = '{1, 10, 100, 1000};
    logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    sum_display #(.REFRESH_DIV(RDIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .seg   (seg),
        .an    (an),
        .bcd   (bcd),
        .busy  (busy)
    );

    // Clock edges seen since reset released; drives the expected scan position.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(int v, int k);
        logic [6:0] t;
        if (k > 0 && v < p10[k]) return 7'h7F;
        t = seg_tab[(v / p10[k]) % 10];
        return ~t;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_scan();
        int k;
        logic [3:0] ea;
        logic [6:0] es;
        if (!scan_en) return;
        if (edge_cnt == 0) begin
            chk("an_idle", 16'(an), 16'h000F);
            chk("seg_idle", 16'(seg), 16'h007F);
        end else begin
            k  = ((edge_cnt - 1) / RDIV) % 4;
            ea = ~(4'b0001 << k);
            es = exp_seg(disp_val, k);
            chk("scan_an", 16'(an), 16'(ea));
            chk("scan_seg", 16'(seg), 16'(es));
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_scan();
    endtask

    // Value already changed at a negedge; expect busy next edge, 13 cycles high.
    task automatic wait_conv(int v);
        int hi;
        hi = 0;
        step();
        chk("busy_rise", 16'(busy), 16'd1);
        if (busy) hi = 1;
        while (busy && hi < 40) begin
            step();
            if (busy) hi++;
        end
        chk("busy_len", 16'(hi), 16'd13);
        chk("bcd", bcd, to_bcd(v));
        disp_val = v;
        tb_last  = v;
    endtask

    task automatic apply(int v);
        value = 12'(v);
        if (v == tb_last) begin
            repeat (3) begin
                step();
                chk("busy_quiet", 16'(busy), 16'd0);
            end
            chk("bcd_hold", bcd, to_bcd(v));
        end else begin
            wait_conv(v);
        end
    endtask

    initial begin
        int s;
        int v1, v2, fin, quiet, n;

        // Reset with value already at 0: nothing to convert, display shows "0".
        rst = 1'b1;
        repeat (3) step();
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_bcd", bcd, 16'h0000);
        rst = 1'b0;
        repeat (2) step();
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_bcd", bcd, 16'h0000);
        repeat (16) step();

        // Maximum value.
        apply(4095);
        repeat (18) step();

        // Leading-zero blanking cases.
        apply(999);
        repeat (18) step();
        apply(7);
        repeat (18) step();

        // Change during a conversion: first value committed, then the new one.
        value = 12'd100;
        s = 0;
        step(); s++;
        chk("t4_rise", 16'(busy), 16'd1);
        step(); s++;
        step(); s++;
        value = 12'd250;
        while (busy && s < 40) begin step(); s++; end
        chk("t4_first_lat", 16'(s), 16'd14);
        chk("t4_first_bcd", bcd, 16'h0100);
        disp_val = 100;
        step(); s++;
        chk("t4_rerise", 16'(busy), 16'd1);
        while (busy && s < 60) begin step(); s++; end
        chk("t4_second_lat", 16'(s), 16'd28);
        chk("t4_second_bcd", bcd, 16'h0250);
        disp_val = 250;
        tb_last  = 250;
        repeat (18) step();

        // Reset in the middle of the shift phase.
        value = 12'd1234;
        step();
        chk("t5_rise", 16'(busy), 16'd1);
        repeat (6) step();
        rst = 1'b1;
        #1;
        chk("t5_busy", 16'(busy), 16'd0);
        chk("t5_bcd", bcd, 16'h0000);
        chk("t5_an", 16'(an), 16'h000F);
        chk("t5_seg", 16'(seg), 16'h007F);
        disp_val = 0;
        tb_last  = 0;
        step();
        rst = 1'b0;
        wait_conv(1234);
        repeat (18) step();

        // Random values, sometimes changed again mid-conversion.
        scan_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v1 = int'($urandom_range(0, 4095));
            value = 12'(v1);
            fin = v1;
            repeat ($urandom_range(0, 15)) step();
            if ($urandom_range(0, 1) == 1) begin
                v2 = int'($urandom_range(0, 4095));
                value = 12'(v2);
                fin = v2;
            end
            quiet = 0;
            n = 0;
            while (quiet < 3 && n < 80) begin
                step();
                n++;
                quiet = busy ? 0 : quiet + 1;
            end
            chk("rand_settle", 16'(quiet), 16'd3);
            chk("rand_bcd", bcd, to_bcd(fin));
            tb_last  = fin;
            disp_val = fin;
        end
        repeat (2) step();
        scan_en = 1'b1;

        // Exhaustive sweep with the scanner checked every cycle.
        for (int v = 0; v < 4096; v++) begin
            apply(v);
        end
        repeat (18) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
